// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing one async FIFO write port between NUM_REQ requesters.
// Optional source-ID tagging of FIFO words: define ASYNC_FIFO_WR_ARB_TAG_EN.
module async_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int ID_W  = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W = $clog2(MAX_BURST + 1),
`ifdef ASYNC_FIFO_WR_ARB_TAG_EN
  localparam int OUT_W = ID_W + DATA_WIDTH
`else
  localparam int OUT_W = DATA_WIDTH
`endif
) (
  input  logic                          clk_a_i,
  input  logic                          a_rst_ni,
  input  logic [NUM_REQ-1:0]            a_req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] a_req_data_i,
  input  logic [NUM_REQ-1:0]            a_req_last_i,
  output logic [NUM_REQ-1:0]            a_req_ready_o,
  output logic [NUM_REQ-1:0]            a_grant_o,
  output logic                          a_busy_o,
  output logic                          a_we_o,
  output logic [OUT_W-1:0]              a_din_o,
  input  logic                          a_wrdy_i
);

  typedef enum logic {IDLE, BURST} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  gidx_q, gidx_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [CNT_W-1:0] beats_q, beats_d;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [DATA_WIDTH-1:0]              pay;
  logic [CNT_W-1:0]                   beats_inc;
  logic [ID_W-1:0]                    hi_idx, lo_idx, pick_idx;
  logic                               hi_vld, lo_vld, pick_vld;
  logic                               vld_g, xfer;

  assign req_data  = a_req_data_i;
  assign pay       = req_data[gidx_q];
  assign vld_g     = a_req_valid_i[gidx_q];
  assign xfer      = (state_q == BURST) & vld_g & a_wrdy_i;
  assign beats_inc = beats_q + CNT_W'(1);

  // Rotating priority: lowest valid index above rr_q wins, else wrap to lowest overall.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (a_req_valid_i[i]) begin
        if (ID_W'(i) > rr_q) begin
          hi_vld = 1'b1;
          hi_idx = ID_W'(i);
        end else begin
          lo_vld = 1'b1;
          lo_idx = ID_W'(i);
        end
      end
    end
    pick_vld = hi_vld | lo_vld;
    pick_idx = hi_vld ? hi_idx : lo_idx;
  end

  always_ff @(posedge clk_a_i or negedge a_rst_ni) begin
    if (!a_rst_ni) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      rr_q    <= ID_W'(NUM_REQ - 1);
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      beats_q <= beats_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    beats_d = beats_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BURST;
          gidx_d  = pick_idx;
          rr_d    = pick_idx;
          beats_d = '0;
        end
      end
      BURST: begin
        if (!vld_g) begin
          state_d = IDLE;
        end else if (xfer) begin
          beats_d = beats_inc;
          if (a_req_last_i[gidx_q] || (beats_inc == CNT_W'(MAX_BURST))) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_busy_o = (state_q == BURST);
    a_we_o   = xfer;
`ifdef ASYNC_FIFO_WR_ARB_TAG_EN
    a_din_o  = xfer ? {gidx_q, pay} : '0;
`else
    a_din_o  = xfer ? pay : '0;
`endif
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign a_grant_o[i]     = a_busy_o & (gidx_q == ID_W'(i));
    assign a_req_ready_o[i] = a_grant_o[i] & a_wrdy_i;
  end

endmodule

// File: doc/async_fifo_wr_arbiter.md
# async_fifo_wr_arbiter

Round-robin, burst-locking write-port arbiter in the clk_a domain that shares the single write port of the N-deep async CDC FIFO between NUM_REQ requesters. Each requester offers words with a valid/ready handshake. The arbiter grants one requester at a time for a burst, and drives the FIFO's write enable and data while honouring the FIFO's write-ready (not-full) flag. It sits directly in front of the FIFO write port; the read side is untouched.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters; must be ≥ 2.
- DATA_WIDTH, 8, payload width per requester.
- MAX_BURST, 4, maximum beats per grant; must be ≥ 1.
- Derived: ID_W = max(1, $clog2(NUM_REQ)); CNT_W = $clog2(MAX_BURST+1).

Ports:
- clk_a_i  in  1  write-domain clock.
- a_rst_ni  in  1  reset a_rst_ni, asynchronous, active-low; clock clk_a_i.
- a_req_valid_i  in  NUM_REQ  per-requester word valid.
- a_req_data_i  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- a_req_last_i  in  NUM_REQ  marks the final word of a requester's burst.
- a_req_ready_o  out  NUM_REQ  per-requester accept.
- a_grant_o  out  NUM_REQ  one-hot registered grant; all zeros when idle.
- a_busy_o  out  1  high while in BURST.
- a_we_o  out  1  FIFO write enable.
- a_din_o  out  OUT_W  FIFO write data; OUT_W is set in Configuration.
- a_wrdy_i  in  1  FIFO not-full.

## Operation
States: IDLE, BURST. Registers:
- state
- grant index gidx (ID_W bits)
- round-robin pointer rr_last (ID_W bits)
- beat counter beats (CNT_W bits)

IDLE:
- If any a_req_valid_i bit is set, select the first set bit searching from rr_last+1 upward, modulo NUM_REQ.
- Load gidx and rr_last with that index, clear beats, and go to BURST.
- No transfer happens in IDLE; a_req_ready_o = 0.

BURST:
- a_req_ready_o[gidx] = a_wrdy_i; all other ready bits are 0.
- Transfer condition: a_req_valid_i[gidx] & a_wrdy_i. On a transfer, a_we_o = 1, a_din_o carries the granted payload, and beats increments.
- Exit to IDLE when either holds:
  - a transfer occurs with a_req_last_i[gidx] = 1;
  - a transfer occurs that makes beats equal MAX_BURST.
- Exit to IDLE with no transfer when a_req_valid_i[gidx] = 0, i.e. the requester abandoned the grant.
- a_wrdy_i = 0 holds the arbiter in BURST with no transfer, and beats does not advance.

Other rules:
- a_we_o is never asserted while a_wrdy_i = 0, so the FIFO never sees a write while full.
- a_grant_o = onehot(gidx) in BURST, zeros in IDLE.
- a_busy_o = (state == BURST).
- A requester whose valid rises while another requester holds the grant waits until the next IDLE. Fairness is strict round-robin at burst granularity.

## Timing
- Reset values:
  - state = IDLE, gidx = 0, rr_last = NUM_REQ-1, beats = 0, so requester 0 has first priority.
  - Outputs: a_we_o = 0, a_req_ready_o = 0, a_grant_o = 0, a_busy_o = 0, a_din_o = 0.
- Arbitration latency: the grant becomes visible one cycle after the IDLE cycle in which valid was seen. The first word can transfer in that same BURST cycle.
- Every burst end costs one idle bubble cycle (the BURST → IDLE → BURST turnaround). Peak throughput is therefore MAX_BURST/(MAX_BURST+1).
- a_we_o, a_din_o and a_req_ready_o are combinational from registered state/gidx and the inputs a_req_valid_i, a_req_data_i and a_wrdy_i. There is no registered output stage, so the FIFO samples the data on the same edge that completes the handshake.
- Reset asserted mid-burst: the arbiter returns to reset values immediately. The in-flight word is not written unless the edge completed before the assertion.

## Configuration
- Macro: ASYNC_FIFO_WR_ARB_TAG_EN.
- Defined: OUT_W = ID_W + DATA_WIDTH. a_din_o = {gidx, payload}, with the source ID in the MSBs. Instantiate the FIFO with DATA_WIDTH = OUT_W.
- Undefined: OUT_W = DATA_WIDTH and a_din_o = payload only. No ID logic exists in the netlist.

## Test plan
- **Single requester with last:** only req 1 presents 3 words 0xA1, 0xA2, 0xA3, with last on 0xA3, and a_wrdy_i = 1.
  - Grant appears one cycle after valid; a_we_o pulses on 3 consecutive cycles with those words.
  - Then IDLE, a_grant_o = 0.
- **Round-robin:** req 0 and req 2 are both continuously valid, each burst = 1 word with last.
  - Grants alternate 0, 2, 0, 2.
  - After reset, req 0 is granted first.
- **Burst cap:** req 3 streams 10 words with no last and MAX_BURST = 4.
  - Writes come in groups of 4 separated by one bubble cycle.
  - Req 3 is re-granted each time when it is the only requester.
- **Back-pressure:** during a req 1 burst, a_wrdy_i = 0 for 5 cycles.
  - a_we_o = 0 and a_req_ready_o[1] = 0 throughout.
  - No data is lost or duplicated, and beats does not advance.
  - The burst resumes when a_wrdy_i returns to 1.
- **Abandon/reset:** req 2 drops valid after 1 of 3 beats.
  - The arbiter returns to IDLE with no write that cycle.
  - Separately, asserting a_rst_ni low mid-burst forces all outputs to 0 asynchronously.
- **Tag (ASYNC_FIFO_WR_ARB_TAG_EN defined, NUM_REQ = 4):** req 3 writes 0x5C.
  - a_din_o = 10'h35C.
  - With the macro undefined, a_din_o = 8'h5C.
